// File: rtl/detector_jogada_if.sv
// Panel-side bundle of the move detector: raw buttons and enable in,
// accepted move, invalid-press flag and debug state out.
interface detector_jogada_if #(
    parameter int N_BOTOES = 4
);
    logic [N_BOTOES-1:0] botoes;
    logic                habilita;
    logic                fez_jogada;
    logic [3:0]          jogada;
    logic                botao_invalido;
    logic [3:0]          db_estado;

    modport master (
        output botoes,
        output habilita,
        input  fez_jogada,
        input  jogada,
        input  botao_invalido,
        input  db_estado
    );

    modport slave (
        input  botoes,
        input  habilita,
        output fez_jogada,
        output jogada,
        output botao_invalido,
        output db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Move detector: synchronises and debounces the panel buttons and emits one
// fez_jogada pulse per accepted single-button press.
module detector_jogada #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic             clock,
    input  logic             reset,
    detector_jogada_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ESTABILIZA = 2'd1,
        DISPARA    = 2'd2,
        SOLTAR     = 2'd3
    } estado_t;

    estado_t             r_estado, w_estado_n;
    logic [N_BOTOES-1:0] r_sync1, r_sync2;
    logic [N_BOTOES-1:0] r_sample, w_sample_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic [3:0]          r_jogada, w_jogada_n;
    logic                r_invalido, w_invalido_n;
    logic [N_BOTOES-1:0] w_bs;
    logic [3:0]          w_idx;
    logic                w_onehot;

    assign w_bs = r_sync2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.botoes;
            r_sync2 <= r_sync1;
        end
    end

    assign w_onehot = (r_sample != '0) &&
                      ((r_sample & (r_sample - 1'b1)) == '0);

    always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (r_sample[i]) w_idx = 4'(i + 1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_sample   <= '0;
            r_cnt      <= '0;
            r_jogada   <= 4'd0;
            r_invalido <= 1'b0;
        end else begin
            r_estado   <= w_estado_n;
            r_sample   <= w_sample_n;
            r_cnt      <= w_cnt_n;
            r_jogada   <= w_jogada_n;
            r_invalido <= w_invalido_n;
        end
    end

    always_comb begin
        w_estado_n   = r_estado;
        w_sample_n   = r_sample;
        w_cnt_n      = r_cnt;
        w_jogada_n   = r_jogada;
        w_invalido_n = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (w_bs != '0) begin
                    w_sample_n = w_bs;
                    w_cnt_n    = '0;
                    w_estado_n = ESTABILIZA;
                end
            end
            ESTABILIZA: begin
                if (w_bs == '0) begin
                    w_cnt_n    = '0;
                    w_estado_n = OCIOSO;
                end else if (w_bs != r_sample) begin
                    w_sample_n = w_bs;
                    w_cnt_n    = '0;
                end else if (r_cnt == CNT_MAX) begin
                    // habilita only matters at this decision point
                    w_cnt_n = '0;
                    if (!w_onehot) begin
                        w_invalido_n = 1'b1;
                        w_estado_n   = SOLTAR;
                    end else if (bus.habilita) begin
                        w_jogada_n = w_idx;
                        w_estado_n = DISPARA;
                    end else begin
                        w_estado_n = SOLTAR;
                    end
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            DISPARA: begin
                w_cnt_n    = '0;
                w_estado_n = SOLTAR;
            end
            SOLTAR: begin
                if (w_bs != '0) begin
                    w_cnt_n = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_cnt_n    = '0;
                    w_estado_n = OCIOSO;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_n    = '0;
                w_estado_n = OCIOSO;
            end
        endcase
    end

    assign bus.fez_jogada     = (r_estado == DISPARA);
    assign bus.jogada         = r_jogada;
    assign bus.botao_invalido = r_invalido;
    assign bus.db_estado      = {2'b00, r_estado};
endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with a pulse scoreboard
// (DEBOUNCE_CICLOS=4, N_BOTOES=4).
module tb_detector_jogada;
    localparam int LAT = 7;

    typedef struct {
        int         cyc;
        logic       inv;
        logic [3:0] jog;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    detector_jogada_if #(.N_BOTOES(4)) bus ();

    detector_jogada #(
        .N_BOTOES(4),
        .DEBOUNCE_CICLOS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_pulse(input int at, input logic inv,
                                input logic [3:0] jog);
        exp_t e;
        e.cyc = at;
        e.inv = inv;
        e.jog = jog;
        q.push_back(e);
    endtask

    // Every pulse seen must match the head of the scoreboard
    always @(negedge clock) begin
        if (reset && (bus.fez_jogada || bus.botao_invalido)) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {31'd0, bus.fez_jogada}, 32'd0);
                chk("unexpected_inv", {31'd0, bus.botao_invalido}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_inv", {31'd0, bus.botao_invalido}, {31'd0, e.inv});
                chk("pulse_fez", {31'd0, bus.fez_jogada}, {31'd0, ~e.inv});
                chk("pulse_jogada", {28'd0, bus.jogada}, {28'd0, e.jog});
            end
        end
    end

    initial begin
        bus.botoes   = 4'b0000;
        bus.habilita = 1'b1;
        tick(3);
        chk("rst_fez", {31'd0, bus.fez_jogada}, 32'd0);
        chk("rst_inv", {31'd0, bus.botao_invalido}, 32'd0);
        chk("rst_jogada", {28'd0, bus.jogada}, 32'd0);
        chk("rst_estado", {28'd0, bus.db_estado}, 32'd0);
        reset = 1'b1;
        tick(5);
        chk("idle_estado", {28'd0, bus.db_estado}, 32'd0);

        // single clean press of button 2
        bus.botoes = 4'b0100;
        expect_pulse(cyc + LAT, 1'b0, 4'd3);
        tick(20);
        bus.botoes = 4'b0000;
        tick(10);
        chk("t1_jogada_hold", {28'd0, bus.jogada}, 32'd3);
        chk("t1_idle", {28'd0, bus.db_estado}, 32'd0);

        // bouncing press of button 0
        bus.botoes = 4'b0001; tick(2);
        bus.botoes = 4'b0000; tick(2);
        bus.botoes = 4'b0001; tick(2);
        bus.botoes = 4'b0000; tick(2);
        bus.botoes = 4'b0001; tick(1);
        bus.botoes = 4'b0000; tick(1);
        bus.botoes = 4'b0001;
        expect_pulse(cyc + LAT, 1'b0, 4'd1);
        tick(15);
        bus.botoes = 4'b0000;
        tick(10);
        chk("t2_jogada", {28'd0, bus.jogada}, 32'd1);
        chk("t2_idle", {28'd0, bus.db_estado}, 32'd0);

        // two buttons together
        bus.botoes = 4'b0011;
        expect_pulse(cyc + LAT, 1'b1, 4'd1);
        tick(20);
        chk("t3_jogada_kept", {28'd0, bus.jogada}, 32'd1);
        bus.botoes = 4'b0000;
        tick(10);

        // enable raised while held must not fire
        bus.habilita = 1'b0;
        bus.botoes   = 4'b0010;
        tick(10);
        chk("t4_soltar", {28'd0, bus.db_estado}, 32'd3);
        bus.habilita = 1'b1;
        tick(10);
        chk("t4_no_move", {28'd0, bus.jogada}, 32'd1);
        bus.botoes = 4'b0000;
        tick(10);
        bus.botoes = 4'b0010;
        expect_pulse(cyc + LAT, 1'b0, 4'd2);
        tick(10);
        chk("t4_jogada", {28'd0, bus.jogada}, 32'd2);
        bus.botoes = 4'b0000;
        tick(10);

        // long hold with a short release glitch
        bus.botoes = 4'b1000;
        expect_pulse(cyc + LAT, 1'b0, 4'd4);
        tick(50);
        bus.botoes = 4'b0000;
        tick(2);
        bus.botoes = 4'b1000;
        tick(3);
        chk("t5_glitch_soltar", {28'd0, bus.db_estado}, 32'd3);
        tick(45);
        bus.botoes = 4'b0000;
        tick(5);
        chk("t5_still_soltar", {28'd0, bus.db_estado}, 32'd3);
        tick(1);
        chk("t5_back_idle", {28'd0, bus.db_estado}, 32'd0);
        chk("t5_jogada", {28'd0, bus.jogada}, 32'd4);
        tick(5);

        // async reset in the middle of debounce
        bus.botoes = 4'b0001;
        tick(4);
        chk("t6_estabiliza", {28'd0, bus.db_estado}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("t6_rst_fez", {31'd0, bus.fez_jogada}, 32'd0);
        chk("t6_rst_inv", {31'd0, bus.botao_invalido}, 32'd0);
        chk("t6_rst_jogada", {28'd0, bus.jogada}, 32'd0);
        chk("t6_rst_estado", {28'd0, bus.db_estado}, 32'd0);
        tick(1);
        reset = 1'b1;
        expect_pulse(cyc + LAT, 1'b0, 4'd1);
        tick(6);
        chk("t6_not_early", {28'd0, bus.jogada}, 32'd0);
        tick(4);
        chk("t6_jogada", {28'd0, bus.jogada}, 32'd1);
        bus.botoes = 4'b0000;
        tick(10);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
